// File: rtl/i2c_burst_reader.sv
// I2C master: writes a register pointer to DEV_ADDR, repeated START, then burst-reads NUM_BYTES bytes.
// Optional build macro CLOCK_STRETCH_EN makes the high phase wait for scl_in before counting.
module i2c_burst_reader #(
    parameter int         CLK_DIV   = 16,
    parameter logic [6:0] DEV_ADDR  = 7'h68,
    parameter int         NUM_BYTES = 6,
    parameter int         CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] reg_addr,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [5:0] rd_index,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, REG, ACK_R, RSTART, ADDR_R, ACK_B, READ, MACK, STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [5:0]       LAST_IDX = 6'(NUM_BYTES - 1);

    state_t           state_reg, state_next;
    logic [1:0]       phase_reg, phase_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [5:0]       byte_reg, byte_next;
    logic [7:0]       tx_reg, tx_next;
    logic [7:0]       rx_reg, rx_next;
    logic [7:0]       reg_addr_reg, reg_addr_next;
    logic [7:0]       rd_data_reg, rd_data_next;
    logic             rd_valid_reg, rd_valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             ack_err_reg, ack_err_next;
    logic             nack_reg, nack_next;
    logic             sda_oe_reg, sda_oe_next;
    logic             scl_oe_reg, scl_oe_next;
    logic             tick, sample, bit_end, hold;

    // Line drive is a pure function of the (next) state so both pins come straight from flops.
    function automatic logic [1:0] line_drive(state_t st, logic [1:0] ph, logic [2:0] bidx,
                                              logic [5:0] byt, logic [7:0] tx);
        logic sda, scl;
        sda = 1'b0;
        scl = (ph < 2'd2);
        case (st)
            IDLE:                begin sda = 1'b0; scl = 1'b0; end
            START:               begin sda = 1'b1; scl = 1'b0; end
            ADDR_W, REG, ADDR_R: sda = ~tx[bidx];
            MACK:                sda = (byt != LAST_IDX);
            RSTART:              sda = (ph == 2'd3);
            STOP:                sda = (ph != 2'd3);
            default:             sda = 1'b0;
        endcase
        return {sda, scl};
    endfunction

`ifdef CLOCK_STRETCH_EN
    assign hold = (state_reg != IDLE) && (phase_reg == 2'd2) && (cnt_reg == '0) && !scl_in;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold = 1'b0;
`endif

    assign tick    = (cnt_reg == CNT_MAX);
    assign sample  = tick && (phase_reg == 2'd2);
    assign bit_end = tick && (phase_reg == 2'd3);

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        byte_next     = byte_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        reg_addr_next = reg_addr_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        ack_err_next  = ack_err_reg;
        nack_next     = nack_reg;

        if (state_reg == IDLE) begin
            cnt_next   = '0;
            phase_next = 2'd0;
        end else if (!hold) begin
            cnt_next = tick ? '0 : cnt_reg + 1'b1;
            if (tick) phase_next = phase_reg + 2'd1;
        end

        case (state_reg)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done_reg) begin
                    state_next    = START;
                    phase_next    = 2'd2;
                    busy_next     = 1'b1;
                    ack_err_next  = 1'b0;
                    byte_next     = '0;
                    reg_addr_next = reg_addr;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = ADDR_W;
                    tx_next    = {DEV_ADDR, 1'b0};
                    bit_next   = 3'd7;
                end
            end
            ADDR_W, REG, ADDR_R: begin
                if (bit_end) begin
                    if (bit_reg == 3'd0) begin
                        case (state_reg)
                            ADDR_W:  state_next = ACK_A;
                            REG:     state_next = ACK_R;
                            default: state_next = ACK_B;
                        endcase
                    end else begin
                        bit_next = bit_reg - 3'd1;
                    end
                end
            end
            ACK_A, ACK_R, ACK_B: begin
                if (sample) begin
                    nack_next = sda_in;
                    if (sda_in) ack_err_next = 1'b1;
                end
                if (bit_end) begin
                    bit_next = 3'd7;
                    if (nack_reg) begin
                        state_next = STOP;
                    end else begin
                        case (state_reg)
                            ACK_A: begin
                                state_next = REG;
                                tx_next    = reg_addr_reg;
                            end
                            ACK_R:   state_next = RSTART;
                            default: state_next = READ;
                        endcase
                    end
                end
            end
            RSTART: begin
                if (bit_end) begin
                    state_next = ADDR_R;
                    tx_next    = {DEV_ADDR, 1'b1};
                    bit_next   = 3'd7;
                end
            end
            READ: begin
                if (sample) begin
                    rx_next = {rx_reg[6:0], sda_in};
                    if (bit_reg == 3'd0) begin
                        rd_data_next  = {rx_reg[6:0], sda_in};
                        rd_valid_next = 1'b1;
                    end
                end
                if (bit_end) begin
                    if (bit_reg == 3'd0) state_next = MACK;
                    else                 bit_next   = bit_reg - 3'd1;
                end
            end
            MACK: begin
                if (bit_end) begin
                    if (byte_reg == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        state_next = READ;
                        byte_next  = byte_reg + 6'd1;
                        bit_next   = 3'd7;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        {sda_oe_next, scl_oe_next} = line_drive(state_next, phase_next, bit_next, byte_next, tx_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            byte_reg     <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            reg_addr_reg <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ack_err_reg  <= 1'b0;
            nack_reg     <= 1'b0;
            sda_oe_reg   <= 1'b0;
            scl_oe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            byte_reg     <= byte_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            reg_addr_reg <= reg_addr_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            ack_err_reg  <= ack_err_next;
            nack_reg     <= nack_next;
            sda_oe_reg   <= sda_oe_next;
            scl_oe_reg   <= scl_oe_next;
        end
    end

    assign sda_oe   = sda_oe_reg;
    assign scl_oe   = scl_oe_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_index = byte_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign ack_err  = ack_err_reg;

endmodule

// File: doc/i2c_burst_reader.md
Name: i2c_burst_reader

Overview:
- Parametrised I2C master for the Position subsystem; the next generation of the single-purpose sensor link.
- On a start request it writes a register pointer to a 7-bit slave, issues a repeated START, then burst-reads NUM_BYTES bytes, streaming each byte out with a valid strobe.
- Drives open-drain SDA/SCL through output-enable pins.
- Feeds the position-estimation logic from IMU-class sensors.

Parameters:
- CLK_DIV, 16, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV); legal range 2..1023
- DEV_ADDR, 7'h68, 7-bit slave address
- NUM_BYTES, 6, bytes per burst read; legal range 1..64
- CNT_W, 10, width of the quarter-period counter; must hold CLK_DIV-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only while busy=0
- reg_addr  in  8  register pointer; captured on the cycle start is accepted
- sda_in  in  1  sampled SDA line
- scl_in  in  1  sampled SCL line (used only with CLOCK_STRETCH_EN)
- sda_oe  out  1  1 = pull SDA low; 0 = release
- scl_oe  out  1  1 = pull SCL low; 0 = release
- rd_data  out  8  received byte
- rd_valid  out  1  one-cycle strobe per received byte
- rd_index  out  6  byte index 0..NUM_BYTES-1, valid with rd_valid
- busy  out  1  high from start acceptance until the STOP completes
- done  out  1  one-cycle pulse when the STOP completes
- ack_err  out  1  sticky NACK flag; cleared on the next accepted start

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high, with one clock.
- Reset values: sda_oe=0, scl_oe=0, rd_data=0, rd_valid=0, rd_index=0, busy=0, done=0, ack_err=0; state=IDLE.
- Reset mid-transfer aborts immediately with both lines released; no STOP is generated.
- Bit timing:
  - Each bit occupies 4 phases of CLK_DIV clk each.
  - Phase 0: SCL low; SDA changes at phase-0 entry.
  - Phase 1: SCL low.
  - Phase 2: SCL released.
  - Phase 3: SCL released.
  - SDA is sampled on the last clk of phase 2.
- State sequence: IDLE -> START -> ADDR_W -> ACK_A -> REG -> ACK_R -> RSTART -> ADDR_R -> ACK_B -> READ -> MACK -> (READ | STOP) -> IDLE.
  - START: SDA falls while SCL is high; takes 2 phases (SDA low at phase 2, SCL low after phase 3).
  - ADDR_W sends {DEV_ADDR,0}; ADDR_R sends {DEV_ADDR,1}; REG sends reg_addr. All are MSB first.
  - ACK states release SDA and sample it. Sampled 1 sets ack_err and jumps to STOP.
  - RSTART: SDA released during SCL low, then SCL released, then SDA pulled low while SCL is high, then SCL pulled low.
  - READ: SDA released; 8 bits shifted in MSB first. After the 8th sample, rd_data/rd_index update and rd_valid pulses for one clk.
  - MACK: drives ACK (sda_oe=1) for bytes 0..NUM_BYTES-2 and NACK (sda_oe=0) for the last byte. rd_index then increments, or goes to STOP after the last byte.
  - STOP: SDA low with SCL low, SCL released, then SDA released while SCL is high. At the end of STOP: done=1 for one clk, busy=0 in the same cycle.
- start while busy=1 is ignored.
- A start on the same cycle as the done pulse is ignored.
- A start on the cycle after done is accepted.
- reg_addr changes after acceptance have no effect.
- Latency for NUM_BYTES=N:
  - 9 bit-times each for ADDR_W, REG, ADDR_R.
  - 9*N bit-times for the read bytes.
  - Plus START, RSTART and STOP overheads.
  - Total is exactly deterministic without stretching.
- The counter wraps from CLK_DIV-1 to 0 and advances the phase.
- rd_index wraps only via the reset to 0 at start acceptance.

Optional Feature:
- Macro: CLOCK_STRETCH_EN.
- Defined: after releasing SCL (phase-2 entry), the phase counter holds at 0 until scl_in=1. Stretch time adds to latency. There is no timeout.
- Undefined: scl_in is ignored and the phases are purely counter-timed.

Test Plan:
- CLK_DIV=4, NUM_BYTES=6, slave model ACKs, reg_addr=8'h3B, slave returns 01..06 -> bus shows D0,3B,Sr,D1; rd_valid pulses six times with rd_data=01..06 and rd_index=0..5; master ACKs bytes 0..4 and NACKs byte 5; STOP, then done one pulse and busy=0.
- Slave NACKs the address byte -> ack_err=1, STOP follows immediately, no rd_valid, done pulses. Next start clears ack_err.
- start pulsed while busy and on the done cycle -> ignored, one transfer only. start on the cycle after done -> a second transfer begins.
- rst asserted during the READ of byte 2 -> next clk: all outputs at reset values, sda_oe=scl_oe=0, state IDLE.
- NUM_BYTES=1 -> single read byte NACKed, rd_index=0. Total clk count from start to done matches the computed deterministic value.
- With CLOCK_STRETCH_EN, slave holds SCL low for 50 clk on bit 3 of REG -> SCL high phase delayed by 50 clk, data intact, no ack_err.
